// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Redirect sources, their priority, and fetch constants.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    REDIR_NONE,
    REDIR_EXC,
    REDIR_JR,
    REDIR_J,
    REDIR_BR
  } redir_src_t;

  function automatic redir_src_t redir_pick(
    input logic exc,
    input logic jr,
    input logic j,
    input logic br
  );
    if (exc)     return REDIR_EXC;
    else if (jr) return REDIR_JR;
    else if (j)  return REDIR_J;
    else if (br) return REDIR_BR;
    else         return REDIR_NONE;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush and an occupancy count.
// Head data is read straight from storage at the read pointer.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop)  rd_ptr <= inc(rd_ptr);
      count <= count + CW'(do_push)
                     - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-based memory issue,
// in-order response tracking, fetch queue and redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC =
    WIDTH'(DEFAULT_RESET_PC),
  parameter int               QDEPTH   = 4,
  parameter int               MAX_OUT  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exc_valid,
  input  logic [WIDTH-1:0] exc_pc,
  input  logic             jr_valid,
  input  logic [WIDTH-1:0] jr_pc,
  input  logic             j_valid,
  input  logic [WIDTH-1:0] j_pc,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             id_valid,
  output logic [WIDTH-1:0] id_instr,
  output logic [WIDTH-1:0] id_pc,
  output logic [WIDTH-1:0] id_pc_plus4,
  input  logic             id_ready
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int QW = $clog2(QDEPTH + 1);
  localparam int SW = ((OW > QW) ? OW : QW) + 1;

  redir_src_t       src;
  logic             redirect;
  logic [WIDTH-1:0] target_raw;
  logic [WIDTH-1:0] target;

  logic [WIDTH-1:0] fetch_pc;
  logic [OW-1:0]    outstanding;
  logic [OW-1:0]    drop_cnt;
  logic [QW-1:0]    occupancy;
  logic [OW-1:0]    trk_count;
  logic [SW-1:0]    in_flight;

  logic             accept;
  logic             dropping;
  logic             keep;
  logic             pop;
  logic [WIDTH-1:0] trk_pc;
  logic [2*WIDTH-1:0] q_head;
  logic [WIDTH-1:0] head_pc;

  always_comb begin
    src        = redir_pick(exc_valid, jr_valid,
                            j_valid, br_valid);
    target_raw = '0;
    unique case (src)
      REDIR_EXC:  target_raw = exc_pc;
      REDIR_JR:   target_raw = jr_pc;
      REDIR_J:    target_raw = j_pc;
      REDIR_BR:   target_raw = br_pc;
      REDIR_NONE: target_raw = '0;
    endcase
  end

  assign redirect = (src != REDIR_NONE);
  assign target   = target_raw
                  & ~WIDTH'(INSTR_BYTES - 1);

  // Credits cover both queued and in-flight words,
  // so a returning response always has a free slot.
  assign in_flight = SW'(occupancy) + SW'(outstanding);
  assign imem_req  = !rst && !redirect
                  && (outstanding < OW'(MAX_OUT))
                  && (in_flight < SW'(QDEPTH));
  assign imem_addr = fetch_pc;

  assign accept   = imem_req && imem_gnt;
  assign dropping = (drop_cnt != '0);
  assign keep     = imem_rvalid && !dropping
                 && !redirect;
  assign pop      = id_valid && id_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + OW'(accept)
                                 - OW'(imem_rvalid);
      if (redirect) begin
        fetch_pc <= target;
        drop_cnt <= outstanding - OW'(imem_rvalid);
      end else begin
        if (accept)
          fetch_pc <= fetch_pc + WIDTH'(INSTR_BYTES);
        if (imem_rvalid && dropping)
          drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  fetch_queue #(
    .DEPTH (MAX_OUT),
    .W     (WIDTH)
  ) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (keep),
    .flush     (redirect),
    .head      (trk_pc),
    .count     (trk_count)
  );

  fetch_queue #(
    .DEPTH (QDEPTH),
    .W     (2 * WIDTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (keep),
    .push_data ({imem_rdata, trk_pc}),
    .pop       (pop),
    .flush     (redirect),
    .head      (q_head),
    .count     (occupancy)
  );

  assign head_pc     = q_head[WIDTH-1:0];
  assign id_valid    = (occupancy != '0);
  assign id_instr    = id_valid ?
                       q_head[2*WIDTH-1:WIDTH] : '0;
  assign id_pc       = id_valid ? head_pc : '0;
  assign id_pc_plus4 = id_valid ?
                       head_pc + WIDTH'(INSTR_BYTES) : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rvalid && outstanding == '0));
      assert (!(accept && outstanding == OW'(MAX_OUT)));
      assert (!(keep && trk_count == '0));
      assert (!(keep && occupancy == QW'(QDEPTH)));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with variable
// latency, directed scenarios and a random redirect phase.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int QDEPTH  = 4;
  localparam int MAX_OUT = 2;

  logic        clk;
  logic        rst;
  logic        exc_valid, jr_valid, j_valid, br_valid;
  logic [31:0] exc_pc, jr_pc, j_pc, br_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_pc_plus4;
  logic        id_ready;

  int checks;
  int failures;
  int cyc;
  int lat;
  int gnt_pct;

  logic [31:0] pq_addr[$];
  int          pq_due[$];

  logic [31:0] exp_fetch;
  logic [31:0] exp_pc;
  logic        prev_redir;

  logic        s_req, s_valid, s_pop;
  logic [31:0] s_addr, s_pc, s_p4, s_instr;

  fetch_unit #(
    .WIDTH    (32),
    .RESET_PC (RESET_PC),
    .QDEPTH   (QDEPTH),
    .MAX_OUT  (MAX_OUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .exc_valid   (exc_valid),
    .exc_pc      (exc_pc),
    .jr_valid    (jr_valid),
    .jr_pc       (jr_pc),
    .j_valid     (j_valid),
    .j_pc        (j_pc),
    .br_valid    (br_valid),
    .br_pc       (br_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .id_ready    (id_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(
    input logic [31:0] a
  );
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] want
  );
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h",
               tag, got, want);
    end
  endtask

  task automatic clear_redir();
    exc_valid = 1'b0;
    jr_valid  = 1'b0;
    j_valid   = 1'b0;
    br_valid  = 1'b0;
  endtask

  // One clock: drive memory, sample, score, advance.
  task automatic step();
    logic        have;
    logic [31:0] tgt;
    int          due;
    imem_gnt = (gnt_pct >= 100) ? 1'b1 :
               ($urandom_range(99) < gnt_pct);
    if (!rst && pq_due.size() > 0 && pq_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pq_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = id_valid;
    s_pc    = id_pc;
    s_p4    = id_pc_plus4;
    s_instr = id_instr;
    s_pop   = id_valid && id_ready;

    have = 1'b1;
    tgt  = '0;
    if (exc_valid)     tgt = exc_pc;
    else if (jr_valid) tgt = jr_pc;
    else if (j_valid)  tgt = j_pc;
    else if (br_valid) tgt = br_pc;
    else               have = 1'b0;
    tgt = {tgt[31:2], 2'b00};

    if (rst) begin
      exp_fetch  = RESET_PC;
      exp_pc     = RESET_PC;
      prev_redir = 1'b0;
    end else begin
      if (prev_redir) check("flush", s_valid, 0);
      if (have) check("req_redir", s_req, 0);
      if (s_req)
        check("max_out", pq_addr.size() < MAX_OUT, 1);
      if (s_req && imem_gnt) begin
        check("req_addr", s_addr, exp_fetch);
        exp_fetch = exp_fetch + 4;
      end
      if (s_pop) begin
        check("id_pc", s_pc, exp_pc);
        check("id_instr", s_instr, mem_word(exp_pc));
        check("id_pc_plus4", s_p4, exp_pc + 4);
        exp_pc = exp_pc + 4;
      end
      if (have) begin
        exp_fetch = tgt;
        exp_pc    = tgt;
      end
      prev_redir = have;
    end

    @(posedge clk);
    if (rst) begin
      pq_addr.delete();
      pq_due.delete();
    end else begin
      if (imem_rvalid) begin
        void'(pq_addr.pop_front());
        void'(pq_due.pop_front());
      end
      if (s_req && imem_gnt) begin
        due = cyc + lat;
        if (pq_due.size() > 0 && due <= pq_due[$])
          due = pq_due[$] + 1;
        pq_addr.push_back(s_addr);
        pq_due.push_back(due);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int   pops;
    logic found;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    lat      = 1;
    gnt_pct  = 100;
    rst      = 1'b1;
    id_ready = 1'b1;
    exc_pc   = '0;
    jr_pc    = '0;
    j_pc     = '0;
    br_pc    = '0;
    clear_redir();
    prev_redir = 1'b0;

    step();
    step();
    check("rst_req", s_req, 0);
    check("rst_valid", s_valid, 0);
    check("rst_pc", s_pc, 0);
    check("rst_instr", s_instr, 0);
    check("rst_pc_plus4", s_p4, 0);

    rst = 1'b0;
    step();
    check("first_req", s_req, 1);
    check("first_addr", s_addr, RESET_PC);
    step();
    check("lat_valid0", s_valid, 0);
    step();
    check("lat_valid", s_valid, 1);
    check("lat_pc", s_pc, RESET_PC);
    check("lat_pc_plus4", s_p4, RESET_PC + 4);
    pops = 0;
    repeat (20) begin
      step();
      if (s_pop) pops++;
    end
    check("throughput", pops, 20);

    rst = 1'b1;
    step();
    rst = 1'b0;
    id_ready = 1'b0;
    repeat (10) step();
    check("stall_req", s_req, 0);
    check("stall_valid", s_valid, 1);
    check("stall_head", s_pc, RESET_PC);
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain_pop", s_pop, 1);
      check("drain_pc", s_pc, RESET_PC + 32'(4 * i));
    end

    lat   = 3;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (pq_due.size() == MAX_OUT && pq_due[0] > cyc)
        found = 1'b1;
      else
        step();
    end
    check("lat3_found", found, 1);
    br_valid = 1'b1;
    br_pc    = 32'h0000_0100;
    step();
    clear_redir();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (s_pop) begin
        check("br_first", s_pc, 32'h0000_0100);
        found = 1'b1;
      end
    end
    check("br_seen", found, 1);

    lat = 1;
    repeat (8) step();
    exc_valid = 1'b1;
    exc_pc    = 32'h0000_0080;
    br_valid  = 1'b1;
    br_pc     = 32'h0000_0200;
    step();
    clear_redir();
    step();
    check("prio_req", s_req, 1);
    check("prio_addr", s_addr, 32'h0000_0080);

    j_valid = 1'b1;
    j_pc    = 32'h0000_1003;
    step();
    clear_redir();
    step();
    check("j_align", s_addr, 32'h0000_1000);

    j_valid = 1'b1;
    j_pc    = 32'hFFFF_FFFC;
    step();
    clear_redir();
    step();
    check("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_addr1", s_addr, 32'h0000_0000);

    id_ready = 1'b0;
    repeat (8) step();
    check("full_valid", s_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    id_ready = 1'b1;
    step();
    check("mrst_valid", s_valid, 0);
    check("mrst_req", s_req, 1);
    check("mrst_addr", s_addr, RESET_PC);
    repeat (6) step();

    for (int i = 0; i < 2000; i++) begin
      if (i % 200 == 0) begin
        lat     = $urandom_range(4, 1);
        gnt_pct = $urandom_range(100, 40);
      end
      rst      = ($urandom_range(999) < 3);
      id_ready = ($urandom_range(99) < 70);
      clear_redir();
      if ($urandom_range(99) < 4) begin
        exc_valid = $urandom_range(1);
        jr_valid  = $urandom_range(1);
        j_valid   = $urandom_range(1);
        br_valid  = !(exc_valid || jr_valid || j_valid)
                  || ($urandom_range(1) == 1);
        exc_pc = $urandom;
        jr_pc  = $urandom;
        j_pc   = $urandom;
        br_pc  = $urandom;
      end
      step();
    end

    rst = 1'b0;
    clear_redir();
    id_ready = 1'b1;
    gnt_pct  = 100;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
